// File: rtl/alu_iter.sv
// Multi-cycle execute-stage ALU: simple ops finish 1 cycle after start, MUL/MULHU/DIVU/REMU after WIDTH+1.
// No backpressure: start is taken only in IDLE and ignored while busy; results are held until the next done.
module alu_iter #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam int SH_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t             r_state;
  logic [3:0]         r_op;
  logic [WIDTH-1:0]   r_opa;
  logic [WIDTH-1:0]   r_opb;
  logic [2*WIDTH-1:0] r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_zc;

  logic [SH_W-1:0]    w_shamt;
  logic [WIDTH-1:0]   w_simple;
  logic               w_iter;
  logic               w_is_mul;
  logic               w_hi_sel;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_step;

  assign busy     = (r_state != S_IDLE);
  assign w_shamt  = SrcB[SH_W-1:0];
  assign w_iter   = (ALUControl >= 4'b1010) && (ALUControl <= 4'b1101);
  assign w_is_mul = (r_op[3:1] == 3'b101);
  assign w_hi_sel = (r_op == 4'b1011) || (r_op == 4'b1101);

  always_comb begin
    w_simple = '0;
    case (ALUControl)
      4'b0000: w_simple = SrcA + SrcB;
      4'b0001: w_simple = SrcA - SrcB;
      4'b0010: w_simple = SrcA & SrcB;
      4'b0011: w_simple = SrcA | SrcB;
      4'b0100: w_simple = SrcA ^ SrcB;
      4'b0101: w_simple = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      4'b0110: w_simple = {{(WIDTH-1){1'b0}}, (SrcA < SrcB)};
      4'b0111: w_simple = SrcA << w_shamt;
      4'b1000: w_simple = SrcA >> w_shamt;
      4'b1001: w_simple = $unsigned($signed(SrcA) >>> w_shamt);
      default: w_simple = '0;
    endcase
  end

  // Accumulator layout: multiply keeps {product_hi, multiplier}; divide keeps {remainder, quotient/dividend}.
  always_comb begin
    w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opa} : {(WIDTH+1){1'b0}});
    w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
    w_div_diff = w_rem_sh - {1'b0, r_opb};
    if (w_is_mul) begin
      w_step = {w_mul_sum, r_acc[WIDTH-1:1]};
    end else if (w_div_diff[WIDTH]) begin
      w_step = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_step = {w_div_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_op      <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_zc      <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op  <= ALUControl;
            r_opa <= SrcA;
            r_opb <= SrcB;
            r_zc  <= (SrcA == SrcB);
            r_cnt <= '0;
            if (w_iter) begin
              r_acc   <= (ALUControl[3:1] == 3'b101) ? {{WIDTH{1'b0}}, SrcB} : {{WIDTH{1'b0}}, SrcA};
              r_state <= S_RUN;
            end else begin
              r_acc   <= {{WIDTH{1'b0}}, w_simple};
              r_state <= S_FIN;
            end
          end
        end
        S_RUN: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + 1'b1;
          // Fixed WIDTH steps even for divide-by-zero, which naturally yields all-ones / dividend.
          if (r_cnt == CNT_W'(WIDTH-1)) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          ALUResult <= w_hi_sel ? r_acc[2*WIDTH-1:WIDTH] : r_acc[WIDTH-1:0];
          Zero      <= r_zc;
          done      <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed bench for alu_iter: WIDTH=32 instance for the main checks, WIDTH=8 instance for parametrisation.
module tb_alu_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  ctl = 4'b0;
  logic [31:0] srca = '0;
  logic [31:0] srcb = '0;
  logic [31:0] res;
  logic        zero, busy, done;

  logic        start8 = 1'b0;
  logic [3:0]  ctl8 = 4'b0;
  logic [7:0]  a8 = '0;
  logic [7:0]  b8 = '0;
  logic [7:0]  res8;
  logic        zero8, busy8, done8;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_iter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .ALUControl(ctl), .SrcA(srca), .SrcB(srcb),
    .ALUResult(res), .Zero(zero), .busy(busy), .done(done)
  );

  alu_iter #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .ALUControl(ctl8), .SrcA(a8), .SrcB(b8),
    .ALUResult(res8), .Zero(zero8), .busy(busy8), .done(done8)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents a request and returns #1 after the sampling edge (edge 0).
  task automatic launch(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    ctl = c; srca = a; srcb = b; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int lat0, output int lat, output int nb);
    lat = lat0;
    nb  = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) nb++;
    end
  endtask

  task automatic op32(input string tag, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_z, input int exp_lat);
    int lat, nb;
    launch(c, a, b);
    wait_done(0, lat, nb);
    chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, "_res"}, 64'(res), 64'(exp_res));
    chk({tag, "_zero"}, 64'(zero), 64'(exp_z));
  endtask

  initial begin
    int lat, nb;
    logic seen;

    #2;
    chk("rst_res", 64'(res), 64'h0);
    chk("rst_zero", 64'(zero), 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_busy8", 64'(busy8), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op32("add",   4'b0000, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0, 1);
    op32("sub",   4'b0001, 32'h5,        32'h5,        32'h00000000, 1'b1, 1);
    op32("slt",   4'b0101, 32'hFFFFFFFF, 32'h1,        32'h00000001, 1'b0, 1);
    op32("sltu",  4'b0110, 32'hFFFFFFFF, 32'h1,        32'h00000000, 1'b0, 1);
    op32("sra",   4'b1001, 32'h80000000, 32'h4,        32'hF8000000, 1'b0, 1);
    op32("srl",   4'b1000, 32'h80000000, 32'h24,       32'h08000000, 1'b0, 1);
    op32("xor",   4'b0100, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 1'b0, 1);
    op32("op_e",  4'b1110, 32'h12345678, 32'h1,        32'h00000000, 1'b0, 1);
    op32("mul",   4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b1, 33);
    op32("mulhu", 4'b1011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b1, 33);
    op32("divu",  4'b1100, 32'd100,      32'd7,        32'd14,       1'b0, 33);
    op32("remu",  4'b1101, 32'd100,      32'd7,        32'd2,        1'b0, 33);
    op32("div0",  4'b1100, 32'h1234,     32'h0,        32'hFFFFFFFF, 1'b0, 33);
    op32("rem0",  4'b1101, 32'h1234,     32'h0,        32'h00001234, 1'b0, 33);

    // busy must stay high for exactly 33 samples of a multiply
    launch(4'b1010, 32'd3, 32'd5);
    wait_done(0, lat, nb);
    chk("mul_busy_cnt", 64'(nb), 64'd33);
    chk("mul_small", 64'(res), 64'd15);
    chk("busy_on_done", 64'(busy), 64'h0);

    // start and operand changes while running are ignored
    launch(4'b1010, 32'd7, 32'd6);
    repeat (5) @(posedge clk);
    #1;
    ctl = 4'b0000; srca = 32'd100; srcb = 32'd100; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(6, lat, nb);
    chk("ign_lat", 64'(lat), 64'd33);
    chk("ign_res", 64'(res), 64'd42);
    chk("ign_zero", 64'(zero), 64'h0);
    chk("ign_busy", 64'(busy), 64'h0);

    // back-to-back: new start presented during the done cycle
    launch(4'b1100, 32'd100, 32'd7);
    wait_done(0, lat, nb);
    chk("b2b1_res", 64'(res), 64'd14);
    launch(4'b0111, 32'h1, 32'h4);
    wait_done(0, lat, nb);
    chk("b2b2_lat", 64'(lat), 64'd1);
    chk("b2b2_res", 64'(res), 64'd16);
    launch(4'b1011, 32'h80000000, 32'h4);
    wait_done(0, lat, nb);
    chk("b2b3_lat", 64'(lat), 64'd33);
    chk("b2b3_res", 64'(res), 64'h2);

    // async reset in the middle of a multiply
    op32("and_eq", 4'b0010, 32'hA5A5A5A5, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1);
    launch(4'b1010, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_res", 64'(res), 64'h0);
    chk("arst_zero", 64'(zero), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_done", 64'(done), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("arst_no_done", 64'(seen), 64'h0);
    chk("arst_idle", 64'(busy), 64'h0);
    chk("arst_res_hold", 64'(res), 64'h0);

    // WIDTH=8 multiply regression
    for (int k = 0; k < 2; k++) begin
      int l8;
      ctl8 = (k == 0) ? 4'b1010 : 4'b1011;
      a8 = 8'hFF; b8 = 8'hFF; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      l8 = 0;
      while (!done8 && l8 < 100) begin
        @(posedge clk);
        #1;
        l8++;
      end
      chk("w8_lat", 64'(l8), 64'd9);
      chk("w8_res", 64'(res8), (k == 0) ? 64'h01 : 64'hFE);
      chk("w8_zero", 64'(zero8), 64'h1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Adds XOR, signed/unsigned compare, shifts, and iterative unsigned multiply/divide (MUL, MULHU, DIVU, REMU).
- Uses a start/busy/done handshake.
- Sits in the execute stage; the control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4, power of 2).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; sampled only in IDLE
- ALUControl  in  4  operation select, sampled with start
- SrcA  in  WIDTH  operand A, sampled with start
- SrcB  in  WIDTH  operand B, sampled with start
- ALUResult  out  WIDTH  registered result, held until next done
- Zero  out  1  registered (SrcA==SrcB) of the accepted request
- busy  out  1  high while state != IDLE
- done  out  1  one-cycle pulse when ALUResult/Zero update

Behaviour:
- Reset: asynchronous active-low. While rst_n=0:
  - state=IDLE; ALUResult=0, Zero=0, done=0, busy=0.
  - Internal operand, accumulator and counter registers = 0.
  - Reset mid-operation aborts the operation with no done pulse.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT: signed, result 1/0 zero-extended. 0110 SLTU: unsigned.
  - 0111 SLL, 1000 SRL, 1001 SRA: shift amount = SrcB[$clog2(WIDTH)-1:0].
  - 1010 MUL: low WIDTH bits of the unsigned product. 1011 MULHU: high WIDTH bits.
  - 1100 DIVU, 1101 REMU.
  - 1110, 1111: result 0.
- States: IDLE, RUN, FIN.
  - IDLE: on start=1, latch op, operands and Zero candidate.
    - Simple op (0000-1001, 111x): go to FIN; result computed into a holding register.
    - Iterative op (1010-1101): go to RUN with count=0.
  - RUN: one radix-2 step per clock. count increments; after the step with count==WIDTH-1, go to FIN.
    - Multiply: shift-add into a 2*WIDTH accumulator.
    - Divide: restoring shift-subtract; quotient and remainder both WIDTH bits.
  - FIN: load ALUResult and Zero, assert done for exactly this cycle's output (registered), return to IDLE.
- Latency (start-sampling edge = edge 0):
  - Simple ops: done=1 after edge 1.
  - Iterative ops: done=1 after edge WIDTH+1 (33 for WIDTH=32).
- busy is combinational from state. It is low in IDLE, including the cycle in which done is high, so back-to-back start on the done cycle is accepted.
- start while busy=1 is ignored: no queueing, and operands are not resampled.
- Operands changing after acceptance have no effect.
- Division by zero (SrcB==0):
  - DIVU result = all ones; REMU result = SrcA.
  - Still takes the full WIDTH+1 latency (fixed latency, no early exit).
- Zero reflects the operands of the last completed operation only. It is unaffected by the result value.
- Arithmetic: ADD/SUB wrap modulo 2^WIDTH; no flags other than Zero.

Test Plan:
- Reset: assert rst_n=0 mid-RUN of a MUL -> all outputs 0 immediately (async), no done. After release, IDLE with busy=0.
- Simple ops, WIDTH=32, one cycle each:
  - ADD 0xFFFFFFFF+1 -> 0x00000000, Zero=0.
  - SUB 5-5 -> 0, Zero=1.
  - SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
  - SRA 0x80000000 by 4 -> 0xF8000000.
  - Each gives done exactly 1 cycle after start.
- Multiply: MUL and MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE. done 33 cycles after start; busy high for 33 cycles.
- Divide:
  - DIVU 100/7 -> 14; REMU -> 2.
  - Divide by zero: DIVU 0x1234/0 -> 0xFFFFFFFF; REMU -> 0x1234.
  - Latency 33.
- Handshake:
  - start pulsed and operands changed during RUN -> ignored, result unaffected.
  - New start on the done cycle -> accepted; next done at the expected latency.
- Parametrisation: WIDTH=8 regression of MUL 0xFF*0xFF (low 0x01, MULHU 0xFE) -> done after 9 cycles.
